// File: rtl/cu_pkg.sv
// Shared definitions for the compute-unit host side: opcodes, instruction
// field positions, the scramble key and the issuer FSM states.
package cu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LOAD = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_NOT  = 4'd6,
    OP_XOR  = 4'd7
  } opcode_e;

  localparam logic [15:0] SCRAMBLE_KEY = 16'hAAAF;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int TGT_HI  = 11;
  localparam int TGT_LO  = 8;
  localparam int SRC0_HI = 7;
  localparam int SRC0_LO = 4;
  localparam int SRC1_HI = 3;
  localparam int SRC1_LO = 0;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_e;

  // The compute unit XORs with the same key, so this both scrambles and descrambles.
  function automatic logic [15:0] scramble(input logic [15:0] instr, input logic [15:0] key);
    return instr ^ key;
  endfunction

endpackage

// File: rtl/cu_instr_issuer_if.sv
// Host/compute-unit signal bundle of the instruction issuer; the issuer
// uses the slave view, the host controller and compute unit the master view.
interface cu_instr_issuer_if #(
  parameter int DEPTH = 8
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          wr_valid;
  logic [7:0]    wr_byte;
  logic          wr_ready;
  logic          start;
  logic [7:0]    cu_ui_in;
  logic [7:0]    cu_uio_in;
  logic          cu_ena;
  logic [7:0]    cu_result;
  logic          res_valid;
  logic [7:0]    res_data;
  logic [IW-1:0] res_index;
  logic          busy;
  logic          done;
  logic          err;

  modport slave (
    input  wr_valid, wr_byte, start, cu_result,
    output wr_ready, cu_ui_in, cu_uio_in, cu_ena,
           res_valid, res_data, res_index, busy, done, err
  );

  modport master (
    output wr_valid, wr_byte, start, cu_result,
    input  wr_ready, cu_ui_in, cu_uio_in, cu_ena,
           res_valid, res_data, res_index, busy, done, err
  );

endinterface

// File: rtl/cu_prog_buf.sv
// Program buffer: pairs incoming bytes (high first) into 16-bit instructions
// and stores them in a DEPTH-entry array readable by index.
module cu_prog_buf #(
  parameter int DEPTH = 8,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrEn_i,
  input  logic [7:0]    wrByte_i,
  input  logic          dropHi_i,
  input  logic          clear_i,
  input  logic [IW-1:0] rdIdx_i,
  output logic [15:0]   rdData_o,
  output logic [IW:0]   count_o,
  output logic          phaseLow_o
);

  logic [15:0] mem_q [DEPTH];
  logic [7:0]  hi_q;
  logic        phaseLow_q;
  logic [IW:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q       <= '0;
      phaseLow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      if (dropHi_i) begin
        phaseLow_q <= 1'b0;
      end else if (wrEn_i) begin
        if (!phaseLow_q) begin
          hi_q       <= wrByte_i;
          phaseLow_q <= 1'b1;
        end else begin
          phaseLow_q <= 1'b0;
          count_q    <= count_q + 1'b1;
        end
      end
      if (clear_i) begin
        count_q <= '0;
      end
    end
  end

  // Storage needs no reset: entries at or above count are never read.
  always_ff @(posedge clk) begin
    if (wrEn_i && phaseLow_q && !dropHi_i) begin
      mem_q[count_q[IW-1:0]] <= {hi_q, wrByte_i};
    end
  end

  assign rdData_o   = mem_q[rdIdx_i];
  assign count_o    = count_q;
  assign phaseLow_o = phaseLow_q;

endmodule

// File: rtl/cu_instr_issuer.sv
// Issues a buffered program to the compute unit one scrambled instruction per
// slot of RESULT_LAT+1 cycles and captures each result at the end of its slot.
module cu_instr_issuer
  import cu_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter int          RESULT_LAT = 2,
  parameter logic [15:0] SCRAMBLE   = SCRAMBLE_KEY
) (
  input logic              clk,
  input logic              rst,
  cu_instr_issuer_if.slave bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(RESULT_LAT + 2);
  localparam logic [SW-1:0] SLOT_LAST = SW'(RESULT_LAT);
  localparam logic [15:0]   NOP_SCR   = scramble(16'h0000, SCRAMBLE);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [SW-1:0] slot_q;
  logic [15:0]   instr_q;
  logic          ena_q;
  logic          resValid_q;
  logic [7:0]    resData_q;
  logic [IW-1:0] resIndex_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [15:0]   rdData;
  logic [IW:0]   count;
  logic          phaseLow;
  logic [IW-1:0] rdIdx;
  logic [15:0]   instr_d;
  logic          startAccept;
  logic          wrReady;
  logic          wrAccept;
  logic          wrDrop;
  logic          lastIdx;

  // A start in IDLE wins over a byte arriving in the same cycle; that byte is dropped.
  assign startAccept = bus.start && (state_q == S_IDLE);
  assign wrReady     = (state_q == S_IDLE) && (count < (IW+1)'(DEPTH));
  assign wrAccept    = bus.wr_valid && wrReady && !startAccept;
  assign wrDrop      = bus.wr_valid && !wrAccept;
  assign lastIdx     = ({1'b0, idx_q} == (count - 1'b1));
  assign rdIdx       = (state_q == S_ISSUE) ? idx_q + 1'b1 : '0;
  assign instr_d     = scramble(rdData, SCRAMBLE);

  cu_prog_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wrEn_i    (wrAccept),
    .wrByte_i  (bus.wr_byte),
    .dropHi_i  (startAccept && phaseLow),
    .clear_i   (state_q == S_DONE),
    .rdIdx_i   (rdIdx),
    .rdData_o  (rdData),
    .count_o   (count),
    .phaseLow_o(phaseLow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      slot_q     <= '0;
      instr_q    <= NOP_SCR;
      ena_q      <= 1'b0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resIndex_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      resValid_q <= 1'b0;
      done_q     <= 1'b0;
      if (wrDrop) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (startAccept) begin
            err_q  <= phaseLow || wrDrop;
            idx_q  <= '0;
            slot_q <= '0;
            if (count != '0) begin
              state_q <= S_ISSUE;
              busy_q  <= 1'b1;
              ena_q   <= 1'b1;
              instr_q <= instr_d;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        // The slot's last edge both samples the result and presents the next instruction.
        S_ISSUE: begin
          if (slot_q == SLOT_LAST) begin
            slot_q     <= '0;
            resValid_q <= 1'b1;
            resData_q  <= bus.cu_result;
            resIndex_q <= idx_q;
            if (lastIdx) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + 1'b1;
              instr_q <= instr_d;
            end
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          ena_q   <= 1'b0;
          busy_q  <= 1'b0;
          instr_q <= NOP_SCR;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_ready  = wrReady;
  assign bus.cu_ui_in  = instr_q[15:8];
  assign bus.cu_uio_in = instr_q[7:0];
  assign bus.cu_ena    = ena_q;
  assign bus.res_valid = resValid_q;
  assign bus.res_data  = resData_q;
  assign bus.res_index = resIndex_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_cu_instr_issuer.sv
// Directed bench for cu_instr_issuer with a behavioural compute unit attached
// and a scoreboard of expected results checked whenever res_valid pulses.
module tb_cu_instr_issuer;
  import cu_pkg::*;

  localparam int DEPTH      = 8;
  localparam int RESULT_LAT = 2;
  localparam int SLOT       = RESULT_LAT + 1;

  typedef struct {
    int idx;
    int data;
    int off;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   runStart = 0;
  int   resCount = 0;
  exp_t sbq[$];

  cu_instr_issuer_if #(.DEPTH(DEPTH)) bus();

  cu_instr_issuer #(
    .DEPTH     (DEPTH),
    .RESULT_LAT(RESULT_LAT),
    .SCRAMBLE  (SCRAMBLE_KEY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural compute unit: descrambles, executes, presents the result RESULT_LAT cycles later.
  logic [15:0] cuInstr;
  logic [7:0]  cuRegs [16];
  logic [7:0]  cuStage1;
  logic [7:0]  cuRes;
  assign cuInstr = scramble({bus.cu_ui_in, bus.cu_uio_in}, SCRAMBLE_KEY);

  always @(posedge clk) begin
    if (bus.cu_ena === 1'b1) begin
      case (opcode_e'(cuInstr[OP_HI:OP_LO]))
        OP_LOAD: cuRes = cuInstr[IMM_HI:IMM_LO];
        OP_ADD:  cuRes = cuRegs[cuInstr[SRC0_HI:SRC0_LO]] + cuRegs[cuInstr[SRC1_HI:SRC1_LO]];
        OP_SUB:  cuRes = cuRegs[cuInstr[SRC0_HI:SRC0_LO]] - cuRegs[cuInstr[SRC1_HI:SRC1_LO]];
        OP_AND:  cuRes = cuRegs[cuInstr[SRC0_HI:SRC0_LO]] & cuRegs[cuInstr[SRC1_HI:SRC1_LO]];
        OP_OR:   cuRes = cuRegs[cuInstr[SRC0_HI:SRC0_LO]] | cuRegs[cuInstr[SRC1_HI:SRC1_LO]];
        OP_NOT:  cuRes = ~cuRegs[cuInstr[SRC0_HI:SRC0_LO]];
        OP_XOR:  cuRes = cuRegs[cuInstr[SRC0_HI:SRC0_LO]] ^ cuRegs[cuInstr[SRC1_HI:SRC1_LO]];
        default: cuRes = 8'h00;
      endcase
      if (cuInstr[OP_HI:OP_LO] != 4'd0) cuRegs[cuInstr[TGT_HI:TGT_LO]] <= cuRes;
      cuStage1 <= cuRes;
    end
    bus.cu_result <= cuStage1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every res_valid must match the head of the scoreboard in index, data and timing.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.res_valid !== 1'b0) begin
      resCount++;
      checkOutput("resValidExpected", {31'd0, bus.res_valid}, {31'd0, sbq.size() != 0});
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checkOutput("resIndex", 32'(bus.res_index), e.idx);
        checkOutput("resData", 32'(bus.res_data), e.data);
        checkOutput("resOffset", cyc - runStart, e.off);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wv, input logic [7:0] b, input logic st);
    bus.wr_valid = wv;
    bus.wr_byte  = b;
    bus.start    = st;
    tick();
    bus.wr_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic waitDone(input int expLat, input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, cyc - runStart, expLat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rc;
    logic sawDone;
    logic [7:0] prog[6];
    prog[0] = 8'h11; prog[1] = 8'h05; prog[2] = 8'h12;
    prog[3] = 8'h03; prog[4] = 8'h23; prog[5] = 8'h12;

    bus.wr_valid = 1'b0;
    bus.wr_byte  = 8'h00;
    bus.start    = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rstUi", 32'(bus.cu_ui_in), 32'hAA);
    checkOutput("rstUio", 32'(bus.cu_uio_in), 32'hAF);
    checkOutput("rstEna", 32'(bus.cu_ena), 0);
    checkOutput("rstBusy", 32'(bus.busy), 0);
    checkOutput("rstErr", 32'(bus.err), 0);
    checkOutput("rstDone", 32'(bus.done), 0);
    checkOutput("rstResValid", 32'(bus.res_valid), 0);
    checkOutput("rstResData", 32'(bus.res_data), 0);
    checkOutput("rstResIndex", 32'(bus.res_index), 0);
    checkOutput("rstWrReady", 32'(bus.wr_ready), 1);
    rst = 1'b0;
    tick();

    $display("[TB] three-instruction program");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, prog[i], 1'b0);
    sbq.push_back('{0, 8'h05, SLOT});
    sbq.push_back('{1, 8'h03, 2 * SLOT});
    sbq.push_back('{2, 8'h08, 3 * SLOT});
    applyStimulus(1'b0, 8'h00, 1'b1);
    runStart = cyc;
    checkOutput("prgBusy", 32'(bus.busy), 1);
    checkOutput("prgEna", 32'(bus.cu_ena), 1);
    checkOutput("prgInstr0", {16'd0, bus.cu_ui_in, bus.cu_uio_in}, 32'hBBAA);
    for (int i = 0; i < SLOT; i++) tick();
    checkOutput("prgInstr1", {16'd0, bus.cu_ui_in, bus.cu_uio_in}, 32'hB8AC);
    for (int i = 0; i < SLOT; i++) tick();
    checkOutput("prgInstr2", {16'd0, bus.cu_ui_in, bus.cu_uio_in}, 32'h89BD);
    waitDone(3 * SLOT + 1, "prgDoneLat");
    checkOutput("prgDoneEna", 32'(bus.cu_ena), 0);
    checkOutput("prgDoneNop", {16'd0, bus.cu_ui_in, bus.cu_uio_in}, 32'hAAAF);
    checkOutput("prgDoneBusy", 32'(bus.busy), 0);
    checkOutput("prgErr", 32'(bus.err), 0);
    tick();
    checkOutput("prgSbEmpty", sbq.size(), 0);
    checkOutput("prgWrReady", 32'(bus.wr_ready), 1);

    $display("[TB] overflow load");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, {4'h1, 4'(i)}, 1'b0);
      if (i == DEPTH - 1) checkOutput("ovfReadyBeforeLast", 32'(bus.wr_ready), 1);
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
      sbq.push_back('{i, 8'h40 + i, SLOT * (i + 1)});
    end
    checkOutput("ovfReadyFull", 32'(bus.wr_ready), 0);
    checkOutput("ovfErrBeforeDrop", 32'(bus.err), 0);
    applyStimulus(1'b1, 8'hEE, 1'b0);
    checkOutput("ovfErrAfterDrop", 32'(bus.err), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    runStart = cyc;
    checkOutput("ovfErrCleared", 32'(bus.err), 0);
    checkOutput("ovfBusy", 32'(bus.busy), 1);
    waitDone(DEPTH * SLOT + 1, "ovfDoneLat");
    tick();
    checkOutput("ovfSbEmpty", sbq.size(), 0);

    $display("[TB] empty start");
    rc = resCount;
    applyStimulus(1'b0, 8'h00, 1'b1);
    runStart = cyc;
    checkOutput("emptyEna", 32'(bus.cu_ena), 0);
    checkOutput("emptyBusy", 32'(bus.busy), 0);
    waitDone(1, "emptyDoneLat");
    checkOutput("emptyEnaAtDone", 32'(bus.cu_ena), 0);
    tick();
    checkOutput("emptyNoResult", resCount - rc, 0);

    $display("[TB] odd byte count");
    rc = resCount;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, prog[i], 1'b0);
    sbq.push_back('{0, 8'h05, SLOT});
    applyStimulus(1'b0, 8'h00, 1'b1);
    runStart = cyc;
    checkOutput("oddErr", 32'(bus.err), 1);
    checkOutput("oddBusy", 32'(bus.busy), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("oddBusyAfterStart", 32'(bus.busy), 1);
    waitDone(SLOT + 1, "oddDoneLat");
    tick();
    checkOutput("oddResultCount", resCount - rc, 1);
    checkOutput("oddSbEmpty", sbq.size(), 0);
    checkOutput("oddErrSticky", 32'(bus.err), 1);

    $display("[TB] reset during issue");
    rc = resCount;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, prog[i], 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    runStart = cyc;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstEna", 32'(bus.cu_ena), 0);
    checkOutput("midRstNop", {16'd0, bus.cu_ui_in, bus.cu_uio_in}, 32'hAAAF);
    checkOutput("midRstBusy", 32'(bus.busy), 0);
    checkOutput("midRstWrReady", 32'(bus.wr_ready), 1);
    checkOutput("midRstErr", 32'(bus.err), 0);
    tick();
    rst = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 4 * SLOT + 4; i++) begin
      tick();
      if (bus.done !== 1'b0) sawDone = 1'b1;
    end
    checkOutput("midRstNoDone", 32'(sawDone), 0);
    checkOutput("midRstNoResult", resCount - rc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
